seven_seg_capture: RTL and testbench
====================================

# seven_seg_capture

Receive-side counterpart of the 3-digit multiplexed seven-segment driver. It samples the active-low digit enables and segment lines of a scanned display bus, waits for each digit phase to settle, and decodes the active segment pattern back to BCD. It assembles the units, tens and hundreds digits into a binary number 0–999. The block sits on the board-test and loopback path, monitoring display pins, and reports each completed frame with a one-cycle valid pulse and each malformed pattern with an error pulse.

## Interface
- SETTLE_CYCLES, 4, number of consecutive cycles the synchronized enable+segment word must hold unchanged before a digit is captured (legal range 1–255).
- clk_12MHz  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- SevenSeg_enable  input  3  digit enables, active low: 110 selects units, 101 selects tens, 011 selects hundreds.
- SegmentSelect  input  7  segments a..g on bits 6..0, active low ("0" = 0000001, "8" = 0000000).
- number  output  10  last assembled value, hundreds*100 + tens*10 + units; holds between frames.
- number_valid  output  1  one-cycle pulse when number is updated.
- digit_error  output  1  one-cycle pulse when a settled phase carries an undecodable segment pattern.
- capture_mask  output  3  digits captured in the current frame: bit0 = units, bit1 = tens, bit2 = hundreds.

## Operation
- Input path: a two-flop synchronizer on all 10 input bits, followed by one register holding the previous synchronized word.
- Stability counter, 8 bits:
  - Clears to 0 when the synchronized word differs from the previous word.
  - Otherwise increments, saturating at SETTLE_CYCLES.
  - A capture event fires in the single cycle the counter transitions from SETTLE_CYCLES-1 to SETTLE_CYCLES. This gives at most one capture per stable phase.
- Capture event with enable 110, 101 or 011:
  - Valid pattern (0–9): decode the segments, write the digit into its slot, and set the matching capture_mask bit. A repeat capture of the same slot before frame completion overwrites it; the latest value wins.
  - Invalid pattern: pulse digit_error, clear capture_mask and all slots, and discard the frame.
- Capture event with any other enable code (111, 000, or any two-low code): ignored. No slot write, no error, and capture_mask is unchanged.
- Frame completion:
  - Occurs when capture_mask becomes 111, regardless of capture order.
  - Next cycle: number is set to h*100+t*10+u, number_valid pulses, and capture_mask is cleared.
  - Multiply by shift-add: h*100 = (h<<6)+(h<<5)+(h<<2); t*10 = (t<<3)+(t<<1). The maximum result is 999 and fits 10 bits with no truncation.
- A capture that arrives in the same cycle as completion belongs to the new frame. Its mask bit is set after the clear.

## Timing
- Reset values:
  - number = 0, number_valid = 0, digit_error = 0, capture_mask = 000.
  - Synchronizer and previous-word registers = 10'h3FF, which is idle: all enables high and all segments off.
  - Stability counter = 0, all slots = 0.
- Reset asserted mid-frame discards partial digits. No number_valid is produced for that frame.
- Input edge to capture event: SETTLE_CYCLES+3 cycles (2 synchronizer + 1 compare + SETTLE_CYCLES).
- Capture of the completing digit to number_valid: 1 cycle. Input edge of the completing phase to number_valid: SETTLE_CYCLES+4 cycles.
- digit_error is asserted in the capture-event cycle.
- A phase shorter than SETTLE_CYCLES+1 cycles of stable synchronized data is never captured.
- number_valid and digit_error are never asserted in the same cycle.

## Structure
- Shared package seven_seg_pkg holds:
  - the enable codes (EN_UNITS = 3'b110, EN_TENS = 3'b101, EN_HUNDREDS = 3'b011);
  - the ten 7-bit segment constants SEG_0..SEG_9;
  - the enable idle value. The display driver and this block both use these.
- One combinational sub-module, seg_pattern_decode: 7-bit pattern in, 4-bit digit plus pattern_ok out. Any of the 118 unlisted patterns gives pattern_ok = 0.
- The top level holds the synchronizer, stability counter, slots, mask and assembly logic.

## Test plan
- Scan 110/0000110 ("3"), 101/0100100 ("5"), 011/1001111 ("1"), each held 20 cycles, SETTLE_CYCLES = 4 -> number = 153, one number_valid pulse 8 cycles after the hundreds phase edge, capture_mask returns to 000.
- Same digits in order hundreds, units, tens -> number = 153. Then scan 9,9,9 -> number = 999 with no overflow.
- Units phase with segments 1111111 -> digit_error pulse and capture_mask = 000. The next full scan of 2,4,7 (units first) -> number = 742 with no stale digits.
- 3-cycle glitch on 101 between stable phases -> no capture and mask unchanged. A 111 blank phase held 50 cycles -> no capture and no error.
- Assert rst for 1 cycle after units and tens are captured -> all outputs return to reset values. No number_valid appears until three new digits are captured.
- Driver-to-capture loopback at the driver's native scan rate for 1000 count steps -> the sequence of number values matches the driver's displayed count, with zero digit_error pulses.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared constants for the 3-digit multiplexed seven-segment display bus.
// Used by both the display driver and the capture (receive) side so the two
// ends agree on enable codes and segment patterns.
//   - EN_*      : active-low digit enable codes (3 bits)
//   - SEG_*     : active-low segment patterns, segments a..g on bits 6..0
//   - bcd3_to_bin : hundreds/tens/units BCD digits to a 10-bit binary value
// -----------------------------------------------------------------------------
package seven_seg_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [2:0] EN_UNITS    = 3'b110;
    localparam logic [2:0] EN_TENS     = 3'b101;
    localparam logic [2:0] EN_HUNDREDS = 3'b011;
    localparam logic [2:0] EN_IDLE     = 3'b111;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;

    // h*100 + t*10 + u using shifts and adds only; 999 is the largest
    // possible result and fits in 10 bits.
    function automatic logic [9:0] bcd3_to_bin(input bcd_t h, input bcd_t t, input bcd_t u);
        logic [9:0] w_h;
        logic [9:0] w_t;
        logic [9:0] w_u;
        w_h = {6'd0, h};
        w_t = {6'd0, t};
        w_u = {6'd0, u};
        return (w_h << 6) + (w_h << 5) + (w_h << 2) + (w_t << 3) + (w_t << 1) + w_u;
    endfunction

endpackage

// File: rtl/seven_seg_capture_if.sv
// -----------------------------------------------------------------------------
// seven_seg_capture_if
// Display bus plus decoded results of the capture block.
//   SevenSeg_enable [2:0] : active-low digit enables (driven by the display side)
//   SegmentSelect   [6:0] : active-low segments a..g (driven by the display side)
//   number          [9:0] : last assembled value
//   number_valid          : one-cycle pulse when number updates
//   digit_error           : one-cycle pulse on an undecodable settled pattern
//   capture_mask    [2:0] : digits captured in the current frame
// Modports: master = display/bus owner, slave = capture block.
// -----------------------------------------------------------------------------
interface seven_seg_capture_if;
    logic [2:0] SevenSeg_enable;
    logic [6:0] SegmentSelect;
    logic [9:0] number;
    logic       number_valid;
    logic       digit_error;
    logic [2:0] capture_mask;

    modport master (
        output SevenSeg_enable, SegmentSelect,
        input  number, number_valid, digit_error, capture_mask
    );

    modport slave (
        input  SevenSeg_enable, SegmentSelect,
        output number, number_valid, digit_error, capture_mask
    );
endinterface

// File: rtl/seg_pattern_decode.sv
// -----------------------------------------------------------------------------
// seg_pattern_decode
// Combinational active-low seven-segment pattern to BCD decoder.
//   i_pattern    [6:0] : segments a..g on bits 6..0, active low
//   o_digit      [3:0] : decoded digit 0..9 (0 when the pattern is unknown)
//   o_pattern_ok       : 1 only for the ten legal digit patterns
// -----------------------------------------------------------------------------
module seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] i_pattern,
    output bcd_t       o_digit,
    output logic       o_pattern_ok
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        o_digit      = 4'd0;
        o_pattern_ok = 1'b1;
        case (i_pattern)
            SEG_0:   o_digit = 4'd0;
            SEG_1:   o_digit = 4'd1;
            SEG_2:   o_digit = 4'd2;
            SEG_3:   o_digit = 4'd3;
            SEG_4:   o_digit = 4'd4;
            SEG_5:   o_digit = 4'd5;
            SEG_6:   o_digit = 4'd6;
            SEG_7:   o_digit = 4'd7;
            SEG_8:   o_digit = 4'd8;
            SEG_9:   o_digit = 4'd9;
            default: o_pattern_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// -----------------------------------------------------------------------------
// seven_seg_capture
// Samples a scanned 3-digit seven-segment display bus, waits for each digit
// phase to settle, decodes it back to BCD and assembles hundreds/tens/units
// into a binary number 0..999.
//   clk_12MHz : system clock, rising edge
//   rst       : synchronous active-high reset
//   bus       : seven_seg_capture_if.slave (display inputs, decoded outputs)
// Parameter SETTLE_CYCLES (1..255): cycles the synchronized word must stay
// unchanged before a digit is captured.
// -----------------------------------------------------------------------------
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                clk_12MHz,
    input  logic                rst,
    seven_seg_capture_if.slave  bus
);

    localparam logic [9:0] IDLE_WORD = {EN_IDLE, SEG_BLANK};
    localparam logic [7:0] SETTLE    = 8'(SETTLE_CYCLES);
    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE_CYCLES - 1);

    logic [9:0] r_sync1;
    logic [9:0] r_sync2;
    logic [9:0] r_prev;
    logic [7:0] r_stable_cnt;
    bcd_t       r_units;
    bcd_t       r_tens;
    bcd_t       r_hundreds;
    logic [2:0] r_mask;
    logic [9:0] r_number;
    logic       r_valid;
    logic       r_error;

    logic       w_stable;
    logic       w_capture;
    logic [2:0] w_slot_sel;
    bcd_t       w_digit;
    logic       w_pattern_ok;
    logic       w_frame_done;

    seg_pattern_decode u_decode (
        .i_pattern    (r_sync2[6:0]),
        .o_digit      (w_digit),
        .o_pattern_ok (w_pattern_ok)
    );

    assign w_stable     = (r_sync2 == r_prev);
    // Fires only on the SETTLE-1 -> SETTLE step, so one capture per phase.
    assign w_capture    = w_stable && (r_stable_cnt == SETTLE_M1);
    assign w_frame_done = (r_mask == 3'b111);

    always_comb begin
        w_slot_sel = 3'b000;
        case (r_sync2[9:7])
            EN_UNITS:    w_slot_sel = 3'b001;
            EN_TENS:     w_slot_sel = 3'b010;
            EN_HUNDREDS: w_slot_sel = 3'b100;
            default:     w_slot_sel = 3'b000;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_12MHz) begin
        if (rst) begin
            r_sync1      <= IDLE_WORD;
            r_sync2      <= IDLE_WORD;
            r_prev       <= IDLE_WORD;
            r_stable_cnt <= 8'd0;
            // NOTE: digit slots are reset too, so a frame interrupted by reset
            // can never leak partial digits into a later number.
            r_units      <= 4'd0;
            r_tens       <= 4'd0;
            r_hundreds   <= 4'd0;
            r_mask       <= 3'b000;
            r_number     <= 10'd0;
            r_valid      <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_sync1 <= {bus.SevenSeg_enable, bus.SegmentSelect};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;

            if (!w_stable) begin
                r_stable_cnt <= 8'd0;
            end else if (r_stable_cnt != SETTLE) begin
                r_stable_cnt <= r_stable_cnt + 8'd1;
            end

            r_valid <= 1'b0;
            r_error <= 1'b0;

            if (w_frame_done) begin
                r_number <= bcd3_to_bin(r_hundreds, r_tens, r_units);
                r_valid  <= 1'b1;
            end

            // Captures on non-digit enable codes fall through untouched.
            if (w_capture && (w_slot_sel != 3'b000)) begin
                if (w_pattern_ok) begin
                    if (w_slot_sel[0]) r_units    <= w_digit;
                    if (w_slot_sel[1]) r_tens     <= w_digit;
                    if (w_slot_sel[2]) r_hundreds <= w_digit;
                    // A capture coinciding with completion starts the new frame.
                    r_mask <= (w_frame_done ? 3'b000 : r_mask) | w_slot_sel;
                end else begin
                    r_error    <= 1'b1;
                    r_mask     <= 3'b000;
                    r_units    <= 4'd0;
                    r_tens     <= 4'd0;
                    r_hundreds <= 4'd0;
                end
            end else if (w_frame_done) begin
                r_mask <= 3'b000;
            end
        end
    end

    assign bus.number       = r_number;
    assign bus.number_valid = r_valid;
    assign bus.digit_error  = r_error;
    assign bus.capture_mask = r_mask;

endmodule

// File: tb/tb_seven_seg_capture.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_capture
// Directed bench for seven_seg_capture: drives scanned display phases,
// queues the expected number for every full frame, and a monitor pops and
// compares on each number_valid pulse.
// -----------------------------------------------------------------------------
module tb_seven_seg_capture;

    localparam int S = 4;

    localparam logic [2:0] U_EN = 3'b110;
    localparam logic [2:0] T_EN = 3'b101;
    localparam logic [2:0] H_EN = 3'b011;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seven_seg_capture_if bus_if ();

    seven_seg_capture #(.SETTLE_CYCLES(S)) dut (
        .clk_12MHz (clk),
        .rst       (rst),
        .bus       (bus_if)
    );

    logic [6:0] seg_tab [10];

    int     total          = 0;
    int     bad            = 0;
    int     err_cnt        = 0;
    int     valid_cnt      = 0;
    int     cyc            = 0;
    int     last_valid_cyc = -1;
    integer exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input integer obs, input integer exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every number_valid pulse must match the oldest
    // expected value; a pulse with nothing queued compares against -1.
    always @(negedge clk) begin
        if (bus_if.digit_error === 1'b1) err_cnt++;
        if (bus_if.number_valid === 1'b1) begin
            integer exp_v;
            valid_cnt++;
            last_valid_cyc = cyc;
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            check("number_on_valid", bus_if.number, exp_v);
            check("valid_error_overlap", bus_if.digit_error, 0);
        end
    end

    task automatic drive(input logic [2:0] en, input logic [6:0] seg, input int n);
        bus_if.SevenSeg_enable = en;
        bus_if.SegmentSelect   = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic digit(input logic [2:0] en, input int d, input int n);
        drive(en, seg_tab[d], n);
    endtask

    task automatic idle(input int n);
        drive(3'b111, 7'b1111111, n);
    endtask

    initial begin
        int h_cyc;
        int err_base;

        seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111;
        seg_tab[2] = 7'b0010010; seg_tab[3] = 7'b0000110;
        seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
        seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0000100;

        rst = 1'b1;
        bus_if.SevenSeg_enable = 3'b111;
        bus_if.SegmentSelect   = 7'b1111111;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_number", bus_if.number, 0);
        check("reset_valid", bus_if.number_valid, 0);
        check("reset_error", bus_if.digit_error, 0);
        check("reset_mask", bus_if.capture_mask, 0);
        idle(10);

        // Basic scan units/tens/hundreds = 3,5,1.
        exp_q.push_back(153);
        digit(U_EN, 3, 20);
        digit(T_EN, 5, 20);
        h_cyc = cyc;
        digit(H_EN, 1, 20);
        check("t1_latency", last_valid_cyc - h_cyc, S + 4);
        check("t1_mask_cleared", bus_if.capture_mask, 0);
        check("t1_number_hold", bus_if.number, 153);
        check("t1_valid_count", valid_cnt, 1);
        idle(10);

        // Out-of-order capture, then the maximum value.
        exp_q.push_back(153);
        digit(H_EN, 1, 20);
        digit(U_EN, 3, 20);
        digit(T_EN, 5, 20);
        exp_q.push_back(999);
        digit(U_EN, 9, 20);
        digit(T_EN, 9, 20);
        digit(H_EN, 9, 20);
        check("t2_number_999", bus_if.number, 999);
        check("t2_valid_count", valid_cnt, 3);
        check("t2_queue_drained", exp_q.size(), 0);
        idle(10);

        // Invalid pattern discards a partial frame.
        digit(H_EN, 5, 20);
        digit(T_EN, 8, 20);
        check("t3_mask_partial", bus_if.capture_mask, 3'b110);
        drive(U_EN, 7'b1111111, 20);
        check("t3_error_pulses", err_cnt, 1);
        check("t3_mask_after_error", bus_if.capture_mask, 0);
        exp_q.push_back(742);
        digit(U_EN, 2, 20);
        check("t3_mask_fresh", bus_if.capture_mask, 3'b001);
        digit(T_EN, 4, 20);
        digit(H_EN, 7, 20);
        check("t3_number_742", bus_if.number, 742);
        check("t3_error_total", err_cnt, 1);
        idle(10);

        // Short glitch and a long blank phase are both ignored.
        digit(U_EN, 3, 20);
        digit(T_EN, 8, 3);
        idle(50);
        check("t4_mask_after_glitch", bus_if.capture_mask, 3'b001);
        check("t4_error_total", err_cnt, 1);
        check("t4_valid_count", valid_cnt, 4);
        exp_q.push_back(153);
        digit(T_EN, 5, 20);
        digit(H_EN, 1, 20);
        check("t4_number_153", bus_if.number, 153);
        idle(10);

        // Mid-frame reset drops captured units and tens.
        digit(U_EN, 2, 20);
        digit(T_EN, 4, 20);
        check("t5_mask_before_rst", bus_if.capture_mask, 3'b011);
        idle(2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_rst_number", bus_if.number, 0);
        check("t5_rst_mask", bus_if.capture_mask, 0);
        check("t5_rst_valid", bus_if.number_valid, 0);
        check("t5_rst_error", bus_if.digit_error, 0);
        idle(10);
        digit(H_EN, 7, 20);
        check("t5_mask_hundreds_only", bus_if.capture_mask, 3'b100);
        check("t5_no_valid_yet", valid_cnt, 5);
        exp_q.push_back(742);
        digit(U_EN, 2, 20);
        digit(T_EN, 4, 20);
        check("t5_number_742", bus_if.number, 742);
        check("t5_valid_count", valid_cnt, 6);
        idle(10);

        // Loopback of a free-running 0..999 counter at driver scan rate.
        err_base = err_cnt;
        for (int n = 0; n < 1000; n++) begin
            exp_q.push_back(n);
            digit(U_EN, n % 10, 8);
            digit(T_EN, (n / 10) % 10, 8);
            digit(H_EN, n / 100, 8);
        end
        idle(10);
        check("t6_no_errors", err_cnt, err_base);
        check("t6_valid_count", valid_cnt, 1006);
        check("t6_queue_drained", exp_q.size(), 0);
        check("t6_final_number", bus_if.number, 999);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
